// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } ch_state_e;

  // Wake counter holds WAKE_CYCLES-1 down to 0.
  function automatic int unsigned wake_cnt_w(input int unsigned wake_cycles);
    return (wake_cycles < 2) ? 1 : $clog2(wake_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_ch.sv
// Single gated-clock channel: idle timeout into OFF, wake with settle period
// and optional acknowledge back to RUN.
module clk_gate_ctrl_ch
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] idle_timeout_i,
  input  logic             gate_allow_i,
  input  logic             busy_i,
  input  logic             wake_req_i,
  output logic             en_o,
  output logic             wake_ack_o,
  output logic             gated_o
);

  localparam int unsigned WCW = wake_cnt_w(WAKE_CYCLES);

  if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
    $error("clk_gate_ctrl_ch: WAKE_CYCLES must be >= 1");
  end

  ch_state_e        state_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [WCW-1:0]   wake_cnt_q;
  logic             wake_ack_q;
  logic             idle;
  logic             timeout_hit;

  assign idle = gate_allow_i & ~busy_i & ~wake_req_i & (idle_timeout_i != '0);
  // >= rather than == so a timeout lowered below the running count gates at once.
  assign timeout_hit = (idle_cnt_q >= (idle_timeout_i - CNT_W'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      wake_ack_q <= 1'b0;
    end else begin
      wake_ack_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          wake_ack_q <= wake_req_i;
          if (!idle) begin
            idle_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q    <= OFF;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        OFF: begin
          if (wake_req_i || busy_i || !gate_allow_i) begin
            state_q    <= WAKE;
            wake_cnt_q <= WCW'(WAKE_CYCLES - 1);
          end
        end
        WAKE: begin
          if (wake_cnt_q == '0) begin
            state_q    <= RUN;
            wake_ack_q <= wake_req_i;
          end else begin
            wake_cnt_q <= wake_cnt_q - WCW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign en_o       = (state_q != OFF);
  assign gated_o    = (state_q == OFF);
  assign wake_ack_o = wake_ack_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gate enable controller; test_en_i forces every enable
// high without disturbing the channel state machines.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CNT_W-1:0]  idle_timeout_i,
  input  logic [NUM_CH-1:0] gate_allow_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] wake_req_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] wake_ack_o,
  output logic [NUM_CH-1:0] gated_o,
  output logic              all_gated_o
);

  logic [NUM_CH-1:0] ch_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_gate_ctrl_ch #(
      .CNT_W       (CNT_W),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .idle_timeout_i (idle_timeout_i),
      .gate_allow_i   (gate_allow_i[c]),
      .busy_i         (busy_i[c]),
      .wake_req_i     (wake_req_i[c]),
      .en_o           (ch_en[c]),
      .wake_ack_o     (wake_ack_o[c]),
      .gated_o        (gated_o[c])
    );
  end

  assign clk_en_o    = ch_en | {NUM_CH{test_en_i}};
  assign all_gated_o = &gated_o;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of each channel.
module tb_clk_gate_ctrl;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CNT_W-1:0]  tmo = '0;
  logic [NUM_CH-1:0] allow = '0;
  logic [NUM_CH-1:0] busy = '0;
  logic [NUM_CH-1:0] req = '0;
  logic              test_en = 1'b0;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] wake_ack;
  logic [NUM_CH-1:0] gated;
  logic              all_gated;

  clk_gate_ctrl #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .idle_timeout_i (tmo),
    .gate_allow_i   (allow),
    .busy_i         (busy),
    .wake_req_i     (req),
    .test_en_i      (test_en),
    .clk_en_o       (clk_en),
    .wake_ack_o     (wake_ack),
    .gated_o        (gated),
    .all_gated_o    (all_gated)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] off;
  } exp_t;

  exp_t exp_q[$];

  bit          m_off[NUM_CH];
  int unsigned m_settle[NUM_CH];    // edges left before RUN; 0 = not waking
  int unsigned m_idle_run[NUM_CH];  // consecutive idle edges seen in RUN
  bit          m_ack[NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_off[c] = 0; m_settle[c] = 0; m_idle_run[c] = 0; m_ack[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit quiet;
      m_ack[c] = 0;
      if (m_settle[c] > 0) begin
        m_settle[c]--;
        if (m_settle[c] == 0) m_ack[c] = req[c];
      end else if (m_off[c]) begin
        if (req[c] || busy[c] || !allow[c]) begin
          m_off[c] = 0;
          m_settle[c] = WAKE_CYCLES;
        end
      end else begin
        m_ack[c] = req[c];
        quiet = allow[c] && !busy[c] && !req[c] && (tmo != 0);
        if (!quiet) m_idle_run[c] = 0;
        else if (m_idle_run[c] + 1 >= int'(tmo)) begin
          m_off[c] = 1;
          m_idle_run[c] = 0;
        end else if (m_idle_run[c] < CNT_SAT) m_idle_run[c]++;
      end
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      e.running[c] = !m_off[c];
      e.ack[c]     = m_ack[c];
      e.off[c]     = m_off[c];
    end
    return e;
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    exp_q.push_back(snapshot());
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("clk_en",    32'(clk_en),    32'(e.running | {NUM_CH{test_en}}));
      check("wake_ack",  32'(wake_ack),  32'(e.ack));
      check("gated",     32'(gated),     32'(e.off));
      check("all_gated", 32'(all_gated), 32'(&e.off));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] b,
                       input logic [NUM_CH-1:0] r, input logic te);
    allow = a; busy = b; req = r; test_en = te;
  endtask

  function automatic logic [NUM_CH-1:0] rand_mask(input int unsigned pct);
    logic [NUM_CH-1:0] m;
    for (int c = 0; c < NUM_CH; c++) m[c] = ($urandom_range(99) < pct);
    return m;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_en", 32'(clk_en), 32'({NUM_CH{1'b1}}));
    check("async_rst_gated",  32'(gated),  32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      tmo = CNT_W'($urandom_range(7));
      drive(rand_mask(50), rand_mask(50), rand_mask(50), 1'b0);
      #3;
      check("reset_clk_en", 32'(clk_en), 32'({NUM_CH{1'b1}}));
      check("reset_ack",    32'(wake_ack), 32'd0);
      check("reset_gated",  32'(gated), 32'd0);
      step(1);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // Auto-gate ch0 with a busy pulse restarting the count
    tmo = CNT_W'(5);
    drive(4'h1, 4'hF, 4'h0, 1'b0);
    step(10);
    busy = 4'hE; step(3);
    busy = 4'hF; step(1);
    busy = 4'hE; step(10);

    // Gate everything, then test override
    drive(4'hF, 4'h0, 4'h0, 1'b0); step(8);
    test_en = 1'b1; #1;
    check("test_en_override", 32'(clk_en), 32'({NUM_CH{1'b1}}));
    check("test_en_gated",    32'(gated),  32'({NUM_CH{1'b1}}));
    step(3);
    test_en = 1'b0;
    step(1);

    // Reset while channels are OFF
    pulse_reset();
    drive(4'hF, 4'h0, 4'h0, 1'b0); step(8);

    // Request wake on ch0, busy wake on ch1
    req = 4'h1; step(5);
    req = 4'h0; step(2);
    busy = 4'h2; step(1);
    busy = 4'h0; step(6);

    // Auto-gating disabled by zero timeout
    busy = 4'hF; step(4);
    tmo = '0; drive(4'hF, 4'h0, 4'h0, 1'b0); step(100);

    // Wake request in RUN
    req = 4'h4; step(1);
    req = 4'h0; step(2);

    // Timeout lowered while a channel is part-way through counting
    tmo = CNT_W'(20); drive(4'h8, 4'h7, 4'h0, 1'b0); step(9);
    tmo = CNT_W'(4); step(4);

    // Random traffic
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(19) == 0) tmo = CNT_W'($urandom_range(6));
        drive(rand_mask(80), rand_mask(20), rand_mask(10), ($urandom_range(15) == 0));
        step(1);
      end
      pulse_reset();
    end

    drive(4'hF, 4'h0, 4'h0, 1'b0);
    step(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
